mem_access_unit: RTL and testbench

//  Memory stage downstream of the ALU: takes ALUResult as a byte address plus

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 57 +++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states,
// byte-enable patterns and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // The size code 11 is never legal, regardless of address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: replicates store data and builds byte enables, and
// picks/extends the addressed lane out of a bus read word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_signed,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        st_wdata = 32'h0;
        st_be    = BE_NONE;
        case (st_size)
            SZ_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = BE_B0 << st_lo;
            end
            SZ_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_lo[1] ? BE_HI : BE_LO;
            end
            SZ_WORD: begin
                st_wdata = st_data;
                st_be    = BE_ALL;
            end
            default: begin
                st_wdata = 32'h0;
                st_be    = BE_NONE;
            end
        endcase
    end

    // Little-endian: lane i lives in bits [8i+7:8i].
    always_comb begin
        b_sel   = ld_rdata[{ld_lo, 3'b000} +: 8];
        h_sel   = ld_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = 32'h0;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_signed & b_sel[7]}}, b_sel};
            SZ_HALF: ld_data = {{16{ld_signed & h_sel[15]}}, h_sel};
            SZ_WORD: ld_data = ld_rdata;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs one sized load/store over a req/ack bus per accepted
// request, with misalignment rejection and a bus timeout.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | ready for a request; req_ready high
//  ST_ACCESS | bus cycle in flight; mem_req high, timeout counter running
//  ST_RESP   | one-cycle resp_valid with ReadData and error flags
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] ReadData,
    output logic        misalign,
    output logic        timeout
);

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        sgn_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [7:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        to_q;

    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;
    logic        accept;
    logic        bad;
    logic        acked;
    logic        expired;

    mem_lane_align u_align (
        .st_size   (MemSize),
        .st_lo     (ALUResult[1:0]),
        .st_data   (WriteData),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ld_size   (size_q),
        .ld_lo     (lo_q),
        .ld_signed (sgn_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign bad     = is_misaligned(MemSize, ALUResult[1:0]);
    assign acked   = (state_q == ST_ACCESS) && mem_ack;
    // Counter is loaded with TIMEOUT-1, so reaching zero marks the last allowed cycle.
    assign expired = (state_q == ST_ACCESS) && !mem_ack && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = bad ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (acked || expired) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            lo_q    <= 2'b00;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            wdata_q <= 32'h0;
            be_q    <= BE_NONE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= {ALUResult[31:2], 2'b00};
                lo_q    <= ALUResult[1:0];
                size_q  <= MemSize;
                we_q    <= MemWrite;
                sgn_q   <= MemSigned;
                wdata_q <= st_wdata;
                be_q    <= st_be;
                cnt_q   <= 8'(TIMEOUT - 1);
                mis_q   <= bad;
                to_q    <= 1'b0;
                if (bad) rdata_q <= 32'h0;
            end else if (acked) begin
                rdata_q <= we_q ? 32'h0 : ld_data;
            end else if (expired) begin
                rdata_q <= 32'h0;
                to_q    <= 1'b1;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_req    = (state_q == ST_ACCESS);
    assign mem_we     = (state_q == ST_ACCESS) && we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_be     = be_q;
    assign resp_valid = (state_q == ST_RESP);
    assign ReadData   = rdata_q;
    assign misalign   = (state_q == ST_RESP) && mis_q;
    assign timeout    = (state_q == ST_RESP) && to_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT overridden to 4).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] ALUResult = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = 2'b00;
    logic        MemSigned = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] ReadData;
    logic        misalign;
    logic        timeout;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemSize    (MemSize),
        .MemSigned  (MemSigned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .ReadData   (ReadData),
        .misalign   (misalign),
        .timeout    (timeout)
    );

    // Presents one request for a single accept edge; returns #1 after that edge (cycle T+1).
    task automatic start_op(input logic [31:0] a, input logic [31:0] wd, input logic we,
                            input logic [1:0] sz, input logic sg);
        @(negedge clk);
        ALUResult = a; WriteData = wd; MemWrite = we; MemSize = sz; MemSigned = sg;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({mem_req, mem_we, resp_valid, misalign, timeout} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {mem_req, mem_we, resp_valid, misalign, timeout}); else passed++;
        checks++; if ({mem_addr, mem_wdata, mem_be, ReadData} !== 100'h0)
            $display("FAIL reset_data got %h %h %h %h want zeros", mem_addr, mem_wdata, mem_be, ReadData); else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_loads();
        logic [31:0] a_t  [6] = '{32'h1003, 32'h2002, 32'h0001, 32'h0004, 32'h0008, 32'h000E};
        logic [1:0]  sz_t [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
        logic        sg_t [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd_t [6] = '{32'h80FF_0000, 32'hBEEF_1234, 32'h0000_9A00, 32'h0000_8001, 32'hDEAD_BEEF, 32'h8001_0000};
        logic [31:0] ex_t [6] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'h0000_009A, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_8001};
        logic [31:0] ad_t [6] = '{32'h1000, 32'h2000, 32'h0000, 32'h0004, 32'h0008, 32'h000C};
        logic [3:0]  be_t [6] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1100};
        int          dl_t [6] = '{0, 1, 0, 2, 0, 3};
        for (int i = 0; i < 6; i++) begin
            start_op(a_t[i], 32'h0, 1'b0, sz_t[i], sg_t[i]);
            @(negedge clk);
            repeat (dl_t[i]) @(negedge clk);
            checks++; if ({mem_req, mem_we, resp_valid} !== 3'b100)
                $display("FAIL ld%0d_bus got req/we/resp=%b want 100", i, {mem_req, mem_we, resp_valid}); else passed++;
            checks++; if (mem_be !== be_t[i]) $display("FAIL ld%0d_be got %b want %b", i, mem_be, be_t[i]); else passed++;
            checks++; if (mem_addr !== ad_t[i]) $display("FAIL ld%0d_addr got %h want %h", i, mem_addr, ad_t[i]); else passed++;
            mem_ack = 1'b1; mem_rdata = rd_t[i];
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_rdata = 32'h0;
            @(negedge clk);
            checks++; if ({resp_valid, mem_req, misalign, timeout} !== 4'b1000)
                $display("FAIL ld%0d_resp got resp/req/mis/to=%b want 1000", i, {resp_valid, mem_req, misalign, timeout}); else passed++;
            checks++; if (ReadData !== ex_t[i]) $display("FAIL ld%0d_data got %h want %h", i, ReadData, ex_t[i]); else passed++;
            @(negedge clk);
            checks++; if ({resp_valid, req_ready} !== 2'b01 || ReadData !== ex_t[i])
                $display("FAIL ld%0d_after got resp/ready=%b data=%h want 01 %h", i, {resp_valid, req_ready}, ReadData, ex_t[i]); else passed++;
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a_t  [5] = '{32'h0006, 32'h0000, 32'h0001, 32'h0003, 32'h0005};
        logic [1:0]  sz_t [5] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 5; i++) begin
            start_op(a_t[i], 32'h0, 1'b0, sz_t[i], 1'b0);
            @(negedge clk);
            checks++; if ({resp_valid, misalign, timeout, mem_req} !== 4'b1100)
                $display("FAIL mis%0d_resp got resp/mis/to/req=%b want 1100", i, {resp_valid, misalign, timeout, mem_req}); else passed++;
            checks++; if (ReadData !== 32'h0) $display("FAIL mis%0d_data got %h want 0", i, ReadData); else passed++;
            @(negedge clk);
            checks++; if ({resp_valid, misalign, req_ready} !== 3'b001)
                $display("FAIL mis%0d_after got resp/mis/ready=%b want 001", i, {resp_valid, misalign, req_ready}); else passed++;
        end
    endtask

    task automatic test_stores();
        logic [31:0] a_t  [4] = '{32'h0013, 32'h0022, 32'h0030, 32'h0040};
        logic [1:0]  sz_t [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [31:0] wd_t [4] = '{32'h0000_00AB, 32'h1234_CDEF, 32'h0123_4567, 32'h5555_55FE};
        logic [31:0] ew_t [4] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h0123_4567, 32'hFEFE_FEFE};
        logic [3:0]  be_t [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0001};
        logic [31:0] ad_t [4] = '{32'h0010, 32'h0020, 32'h0030, 32'h0040};
        for (int i = 0; i < 4; i++) begin
            start_op(a_t[i], wd_t[i], 1'b1, sz_t[i], 1'b0);
            @(negedge clk);
            checks++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL st%0d_bus got req/we=%b want 11", i, {mem_req, mem_we}); else passed++;
            checks++; if (mem_wdata !== ew_t[i]) $display("FAIL st%0d_wdata got %h want %h", i, mem_wdata, ew_t[i]); else passed++;
            checks++; if (mem_be !== be_t[i]) $display("FAIL st%0d_be got %b want %b", i, mem_be, be_t[i]); else passed++;
            checks++; if (mem_addr !== ad_t[i]) $display("FAIL st%0d_addr got %h want %h", i, mem_addr, ad_t[i]); else passed++;
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            @(posedge clk);
            #1 mem_ack = 1'b0; mem_rdata = 32'h0;
            @(negedge clk);
            checks++; if ({resp_valid, mem_we, ReadData} !== {2'b10, 32'h0})
                $display("FAIL st%0d_resp got resp/we=%b data=%h want 10 0", i, {resp_valid, mem_we}, ReadData); else passed++;
        end
    endtask

    task automatic test_ack_outside();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        checks++; if ({resp_valid, mem_req, req_ready} !== 3'b001)
            $display("FAIL stray_ack got resp/req/ready=%b want 001", {resp_valid, mem_req, req_ready}); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] seen;
        @(negedge clk);
        ALUResult = 32'h0002; MemSize = 2'b10; MemWrite = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen[i] = resp_valid;
        end
        req_valid = 1'b0;
        checks++; if (seen !== 3'b101) $display("FAIL b2b_resp_pattern got %b want 101", seen); else passed++;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        start_op(32'h0050, 32'h0, 1'b0, 2'b10, 1'b0);
        mem_rdata = 32'h1122_3344;
        n = 0;
        @(negedge clk);
        while (mem_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        mem_rdata = 32'h0;
        checks++; if (n !== 4) $display("FAIL to_req_cycles got %0d want 4", n); else passed++;
        checks++; if ({resp_valid, timeout, misalign} !== 3'b110)
            $display("FAIL to_resp got resp/to/mis=%b want 110", {resp_valid, timeout, misalign}); else passed++;
        checks++; if (ReadData !== 32'h0) $display("FAIL to_data got %h want 0", ReadData); else passed++;
        @(negedge clk);
        checks++; if ({resp_valid, timeout, req_ready} !== 3'b001)
            $display("FAIL to_after got resp/to/ready=%b want 001", {resp_valid, timeout, req_ready}); else passed++;
    endtask

    task automatic test_reset_mid();
        logic bad_seen;
        start_op(32'h0004, 32'h0, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        checks++; if (ReadData !== 32'hCAFE_F00D) $display("FAIL rm_preload got %h want cafef00d", ReadData); else passed++;
        start_op(32'h0040, 32'h0, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) $display("FAIL rm_in_access got %b want 1", mem_req); else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, resp_valid, req_ready} !== 3'b001)
            $display("FAIL rm_after_rst got req/resp/ready=%b want 001", {mem_req, resp_valid, req_ready}); else passed++;
        bad_seen = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) bad_seen = 1'b1;
        end
        checks++; if (bad_seen !== 1'b0) $display("FAIL rm_quiet got activity=%b want 0", bad_seen); else passed++;
        checks++; if (ReadData !== 32'h0) $display("FAIL rm_data got %h want 0", ReadData); else passed++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misalign();
        test_stores();
        test_ack_outside();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
